// File: rtl/pix_mode_mux_pkg.sv
// Shared types, mode-code offsets and colour helpers for the pixel mode multiplexer.
package pix_mode_mux_pkg;

  // Mode codes above the grayscale channels, as offsets from NCH.
  localparam int unsigned MODE_RGB565_OFS  = 0;
  localparam int unsigned MODE_PATTERN_OFS = 1;
  localparam int unsigned MODE_BLANK_OFS   = 2;

  typedef struct packed {
    logic        valid;
    logic [23:0] color;
  } pix_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

  // Colour-bar table: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    unique case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // Each field widened by replicating its MSBs into the low bits.
  function automatic logic [23:0] rgb565(input logic [15:0] w);
    return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
  endfunction

endpackage

// File: rtl/pix_dly_line.sv
// Fixed-depth shift register with asynchronous reset to a configurable value.
module pix_dly_line #(
  parameter int unsigned      Width  = 1,
  parameter int unsigned      Depth  = 1,
  parameter logic [Width-1:0] RstVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage_q [Depth];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) stage_q[i] <= RstVal;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < int'(Depth); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[Depth-1];

endmodule

// File: rtl/pix_mode_mux.sv
// Pixel output formatter: mode-selected colour decode, sync alignment, frame-locked
// mode switching and read-underflow accounting.
module pix_mode_mux
  import pix_mode_mux_pkg::*;
#(
  parameter int unsigned DATA_WD  = 16,
  parameter int unsigned CHAN_WD  = 8,
  parameter int unsigned SYNC_DLY = 3,
  parameter int unsigned DATA_DLY = 1,
  parameter bit          VS_POL   = 1'b1,
  parameter bit          HS_POL   = 1'b1,
  parameter int unsigned BAR_W    = 80,
  parameter logic [23:0] BG_COLOR = 24'h0000FF,
  parameter int unsigned MODE_RST = 0,
  localparam int unsigned NCH     = DATA_WD / CHAN_WD,
  localparam int unsigned MW      = clog2(NCH + 3)
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               mode_step,
  input  logic               mode_load,
  input  logic [MW-1:0]      mode_in,
  input  logic               vs_in,
  input  logic               hs_in,
  input  logic               de_in,
  input  logic               pix_valid,
  input  logic [DATA_WD-1:0] pix_data,
  input  logic               ufl_clr,
  output logic               rgb_vs,
  output logic               rgb_hs,
  output logic               rgb_de,
  output logic [23:0]        rgb_data,
  output logic [MW-1:0]      mode_cur,
  output logic               ufl_flag,
  output logic [15:0]        ufl_cnt
);

  localparam int unsigned PW = clog2(BAR_W + 1);

  logic [MW-1:0] mode_q, mode_d, pend_q, pend_d;
  logic          vs_prev_q, frame_start;
  logic [PW-1:0] px_q, px_d;
  logic [2:0]    bar_q, bar_d;
  logic [15:0]   ufl_cnt_q, ufl_cnt_d;
  logic          ufl_flag_q, ufl_flag_d, ufl_hit;
  logic [CHAN_WD-1:0] chan;
  logic [7:0]    gray;
  logic [15:0]   rgb_src;
  pix_t          pix_sel, pix_dly;

  assign frame_start = (vs_in == VS_POL) && (vs_prev_q != VS_POL);

  always_comb begin
    pend_d = pend_q;
    if (mode_load) begin
      pend_d = mode_in;
    end else if (mode_step) begin
      pend_d = (32'(mode_q) < NCH + MODE_BLANK_OFS) ? mode_q + MW'(1) : '0;
    end
    mode_d = frame_start ? pend_q : mode_q;
  end

  // Bar position tracked as (pixel within bar, bar index) to avoid a divider.
  always_comb begin
    px_d  = '0;
    bar_d = '0;
    if (de_in) begin
      if (32'(px_q) == BAR_W - 1) begin
        bar_d = bar_q + 3'd1;
      end else begin
        px_d  = px_q + PW'(1);
        bar_d = bar_q;
      end
    end
  end

  if (CHAN_WD >= 8) begin : g_gray_top
    assign gray = chan[CHAN_WD-1 -: 8];
  end else begin : g_gray_ext
    assign gray = {{(8 - CHAN_WD){1'b0}}, chan};
  end

  if (DATA_WD >= 16) begin : g_rgb_src
    assign rgb_src = pix_data[15:0];
  end else begin : g_rgb_none
    assign rgb_src = '0;
  end

  always_comb begin
    chan          = pix_data[32'(mode_q) * CHAN_WD +: CHAN_WD];
    pix_sel.color = '0;
    pix_sel.valid = 1'b1;
    if (32'(mode_q) < NCH) begin
      pix_sel.color = {3{gray}};
      pix_sel.valid = pix_valid;
    end else if (32'(mode_q) == NCH + MODE_RGB565_OFS && DATA_WD >= 16) begin
      pix_sel.color = rgb565(rgb_src);
      pix_sel.valid = pix_valid;
    end else if (32'(mode_q) == NCH + MODE_PATTERN_OFS) begin
      pix_sel.color = bar_color(bar_q);
    end
  end

  pix_dly_line #(
    .Width  (25),
    .Depth  (DATA_DLY),
    .RstVal (25'd0)
  ) u_data_dly (
    .clk_i (sys_clk),
    .rst_i (sys_rst),
    .d_i   (pix_sel),
    .q_o   (pix_dly)
  );

  pix_dly_line #(
    .Width  (3),
    .Depth  (SYNC_DLY),
    .RstVal ({~VS_POL, ~HS_POL, 1'b0})
  ) u_sync_dly (
    .clk_i (sys_clk),
    .rst_i (sys_rst),
    .d_i   ({vs_in, hs_in, de_in}),
    .q_o   ({rgb_vs, rgb_hs, rgb_de})
  );

  assign ufl_hit = rgb_de & ~pix_dly.valid;

  // A clear and a hit in the same cycle leave exactly one counted underflow.
  always_comb begin
    ufl_cnt_d  = ufl_cnt_q;
    ufl_flag_d = ufl_flag_q;
    if (ufl_clr) begin
      ufl_cnt_d  = '0;
      ufl_flag_d = 1'b0;
    end
    if (ufl_hit) begin
      ufl_flag_d = 1'b1;
      if (ufl_cnt_d != 16'hFFFF) ufl_cnt_d = ufl_cnt_d + 16'd1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mode_q     <= MW'(MODE_RST);
      pend_q     <= MW'(MODE_RST);
      vs_prev_q  <= ~VS_POL;
      px_q       <= '0;
      bar_q      <= '0;
      ufl_cnt_q  <= '0;
      ufl_flag_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      pend_q     <= pend_d;
      vs_prev_q  <= vs_in;
      px_q       <= px_d;
      bar_q      <= bar_d;
      ufl_cnt_q  <= ufl_cnt_d;
      ufl_flag_q <= ufl_flag_d;
    end
  end

  always_comb begin
    rgb_data = '0;
    if (rgb_de) rgb_data = pix_dly.valid ? pix_dly.color : BG_COLOR;
  end

  assign mode_cur = mode_q;
  assign ufl_cnt  = ufl_cnt_q;
  assign ufl_flag = ufl_flag_q;

endmodule

// File: doc/pix_mode_mux.md
Name: pix_mode_mux

Overview:
- Pixel-domain output formatter between the frame-buffer read port and the DVI/TMDS transmitter.
- Selects one of several display modes from packed frame-buffer words:
  - per-byte grayscale channels
  - RGB565 colour decode
  - internal colour-bar test pattern
  - blank
- Delays sync signals to align with the pixel data, and accepts mode changes only at frame boundaries.
- Counts read underflows, where active video occurs without valid pixel data.

Parameters:
- DATA_WD, 16, width of frame-buffer word; multiple of CHAN_WD
- CHAN_WD, 8, width of one grayscale channel
- SYNC_DLY, 3, cycles of delay on vs/hs/de (>=1)
- DATA_DLY, 1, cycles from pix_valid/pix_data to rgb_data (>=1)
- VS_POL, 1, active level of vs_in/rgb_vs
- HS_POL, 1, active level of hs_in/rgb_hs
- BAR_W, 80, test-pattern bar width in pixels
- BG_COLOR, 24'h0000FF, colour driven when de is high but data is invalid
- MODE_RST, 0, mode after reset

Ports:
- sys_clk  in  1  pixel clock; all logic on rising edge
- sys_rst  in  1  asynchronous, active-high reset
- mode_step  in  1  one-cycle pulse; requests next mode
- mode_load  in  1  one-cycle pulse; requests mode_in
- mode_in  in  MW  direct mode value; MW = clog2(NCH+3), NCH = DATA_WD/CHAN_WD
- vs_in  in  1  vertical sync from timing generator
- hs_in  in  1  horizontal sync from timing generator
- de_in  in  1  display-enable from timing generator
- pix_valid  in  1  frame-buffer read-data valid
- pix_data  in  DATA_WD  frame-buffer read data
- ufl_clr  in  1  clears underflow counter and flag
- rgb_vs  out  1  delayed vertical sync
- rgb_hs  out  1  delayed horizontal sync
- rgb_de  out  1  delayed display-enable
- rgb_data  out  24  {r,g,b}
- mode_cur  out  MW  mode currently applied
- ufl_flag  out  1  sticky underflow flag
- ufl_cnt  out  16  saturating underflow pixel count

Behaviour:
- Reset (async, sys_rst=1):
  - rgb_vs = ~VS_POL; rgb_hs = ~HS_POL; rgb_de = 0; rgb_data = 0
  - all sync/data pipeline stages take these same values
  - mode_cur = MODE_RST; pending mode = MODE_RST
  - ufl_flag = 0; ufl_cnt = 0; bar counter = 0
- Mode encoding:
  - 0..NCH-1: grayscale channel k = pix_data[k*CHAN_WD +: CHAN_WD], output {g,g,g} using top 8 bits (zero-extended if CHAN_WD<8)
  - NCH: RGB565 decode of pix_data[15:0], each field MSB-replicated to 8 bits; only legal when DATA_WD>=16, otherwise treated as blank
  - NCH+1: test pattern
  - NCH+2: blank, output 0
  - any other code: blank
- Mode requests:
  - mode_step sets pending = mode_cur+1 if mode_cur < NCH+2, else 0.
  - mode_load sets pending = mode_in.
  - If both pulse in the same cycle, mode_load wins.
  - A request in the cycle of a frame boundary is still captured into pending; it applies at the next boundary.
- Frame boundary: the first cycle in which vs_in equals VS_POL after having been ~VS_POL.
  - At a boundary, mode_cur <= pending.
  - The new mode affects pixels from that cycle's next input onward.
  - Mode never changes mid-frame.
- Sync path: rgb_vs/hs/de are vs_in/hs_in/de_in delayed by exactly SYNC_DLY cycles.
- Data path:
  - Stage 1 registers the mode-selected colour (or pattern colour) plus a valid bit = pix_valid, or 1 in pattern/blank modes.
  - The remaining DATA_DLY-1 stages delay that colour and valid bit.
  - Output: rgb_data = stage valid ? stage colour : BG_COLOR when the delayed de (rgb_de) is high; 0 when rgb_de is low.
- Test pattern:
  - Pixel counter increments on each de_in=1 cycle and resets to 0 on any de_in=0 cycle.
  - bar = (count/BAR_W) mod 8, giving white, yellow, cyan, green, magenta, red, blue, black (8-bit full-scale components).
  - Pattern colour passes through the DATA_DLY pipeline.
- Underflow:
  - Each cycle with rgb_de=1 and delayed valid=0 is an underflow: ufl_cnt += 1, saturating at 16'hFFFF, and ufl_flag <= 1.
  - ufl_clr zeroes both. If ufl_clr and an underflow occur in the same cycle, the result is ufl_cnt = 1 and ufl_flag = 1.
- Reset mid-frame: all outputs go to their reset values immediately; after release, mode changes wait for the next frame boundary.

Decomposition:
- Shared package holds:
  - mode-code constants MODE_BLANK_OFS = 2 and MODE_RGB565_OFS = 0, relative to NCH
  - colour-bar table (8 x 24-bit)
  - clog2 function
- One natural sub-module: pix_dly_line, a parametrised width/depth shift register with async reset and a reset value. It is used for both the sync path and the data path.

Test Plan:
- Reset, then SYNC_DLY=3 and DATA_DLY=1: drive de_in high for 4 cycles with pix_data=16'hA55A, valid=1, mode 0 -> rgb_de high 3 cycles later; rgb_data=24'h5A5A5A.
- mode_step pulse mid-frame -> mode_cur stays 0 until the next vs_in rising edge, then becomes 1; the next active pixel with 16'hA55A gives 24'hA5A5A5.
- mode_load with mode_in=2 (RGB565) and pix_data=16'hF800 -> rgb_data=24'hFF0000 after the next boundary.
- Simultaneous mode_step and mode_load(mode_in=4) -> mode_cur=4 (blank) after the boundary; rgb_data=0 during de.
- Pattern mode, BAR_W=80, 640-pixel line -> pixels 0..79 are 24'hFFFFFF, 80..159 are 24'hFFFF00, 560..639 are 24'h000000; the counter restarts on the next line.
- Mode 0, de_in high for 5 cycles with pix_valid low -> rgb_data=24'h0000FF for 5 cycles, ufl_cnt=5, ufl_flag=1; then ufl_clr -> both return to 0. Also force ufl_cnt to 16'hFFFF -> it holds at 16'hFFFF on further underflows.
